// File: rtl/sig_frame_decoder_if.sv
// Stream bundle for the frame decoder: word input side and payload FIFO output side.
// The decoder takes the slave view; the producer/consumer pair takes the master view.
interface sig_frame_decoder_if #(
    parameter int DATA_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W+2:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/sig_frame_decoder.sv
// Framed-symbol decoder: marker/parity checks, HUNT/SYNC lock tracking,
// show-ahead payload FIFO and a saturating bad-word counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_HUNT | searching for lock; accepted words are checked and discarded
// ST_SYNC | locked; accepted words are pushed into the output FIFO
module sig_frame_decoder #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int LOCK_N = 3,
    parameter int LOSS_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sig_frame_decoder_if.slave   bus,
    input  logic [1:0]           i_mode,
    input  logic                 i_drop_err,
    input  logic                 i_err_clr,
    output logic                 o_locked,
    output logic [CNT_W-1:0]     o_err_count
);
    localparam int IN_W = DATA_W + 3;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int GR_W = $clog2(LOCK_N + 1);
    localparam int BR_W = $clog2(LOSS_N + 1);

    localparam logic [0:0]      ST_HUNT   = 1'b0;
    localparam logic [0:0]      ST_SYNC   = 1'b1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
    localparam logic [GR_W-1:0] LOCK_LAST = GR_W'(LOCK_N - 1);
    localparam logic [BR_W-1:0] LOSS_LAST = BR_W'(LOSS_N - 1);

    logic [0:0]        r_state;
    logic [GR_W-1:0]   r_good_run;
    logic [BR_W-1:0]   r_bad_run;
    logic [DATA_W:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CNT_W-1:0]  r_err_count;

    logic              w_marker_err;
    logic              w_parity_err;
    logic              w_bad;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_payload;
    logic [DATA_W:0]   w_head;

    assign w_marker_err = !bus.in_data[IN_W-1] | !bus.in_data[0];
    assign w_parity_err = ^bus.in_data[IN_W-2:1];
    assign w_payload    = bus.in_data[IN_W-2:2];

    always_comb begin
        w_bad = 1'b0;
        case (i_mode)
            2'd0:    w_bad = 1'b0;
            2'd1:    w_bad = w_marker_err;
            default: w_bad = w_marker_err | w_parity_err;
        endcase
    end

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_push   = w_accept && (r_state == ST_SYNC) && !(w_bad && i_drop_err);
    assign w_pop    = bus.out_valid && bus.out_ready;

    // in_ready is gated by rst_n directly so it reads 0 throughout reset
    assign bus.in_ready = rst_n && !w_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_good_run <= '0;
            r_bad_run  <= '0;
        end else if (w_accept) begin
            if (r_state == ST_HUNT) begin
                if (w_bad) begin
                    r_good_run <= '0;
                end else if (r_good_run == LOCK_LAST) begin
                    r_state    <= ST_SYNC;
                    r_good_run <= '0;
                    r_bad_run  <= '0;
                end else begin
                    r_good_run <= r_good_run + 1'b1;
                end
            end else begin
                if (!w_bad) begin
                    r_bad_run <= '0;
                end else if (r_bad_run == LOSS_LAST) begin
                    r_state    <= ST_HUNT;
                    r_good_run <= '0;
                    r_bad_run  <= '0;
                end else begin
                    r_bad_run <= r_bad_run + 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; emptiness is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_bad, w_payload};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (i_err_clr) begin
            r_err_count <= '0;
        end else if (w_accept && w_bad && !(&r_err_count)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign bus.out_err   = !w_empty && w_head[DATA_W];
    assign o_locked      = (r_state == ST_SYNC);
    assign o_err_count   = r_err_count;
endmodule

// File: tb/tb_sig_frame_decoder.sv
// Directed bench for sig_frame_decoder: vector table for lock/check behaviour,
// hand sequences for backpressure, counter saturation and mid-stream reset.
module tb_sig_frame_decoder;
    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       drop_err;
    logic       err_clr;
    logic       locked;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    sig_frame_decoder_if #(.DATA_W(6)) bus ();

    sig_frame_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .i_mode      (mode),
        .i_drop_err  (drop_err),
        .i_err_clr   (err_clr),
        .o_locked    (locked),
        .o_err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [8:0] data;
        logic [1:0] md;
        logic       drop;
        logic       ordy;
        logic       clr;
        logic       e_ov;
        logic [5:0] e_od;
        logic       e_oe;
        logic       e_lk;
        logic [7:0] e_cnt;
        logic       e_ir;
    } vec_t;

    vec_t vecs [23];

    function automatic logic [8:0] mkw(input logic [5:0] p);
        return {1'b1, p, ^p, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ov, input logic [5:0] e_od,
                           input logic e_oe, input logic e_lk, input logic [7:0] e_cnt,
                           input logic e_ir);
        chk({tag, "_ov"},  32'(bus.out_valid), 32'(e_ov));
        chk({tag, "_od"},  32'(bus.out_data),  32'(e_od));
        chk({tag, "_oe"},  32'(bus.out_err),   32'(e_oe));
        chk({tag, "_lk"},  32'(locked),        32'(e_lk));
        chk({tag, "_cnt"}, 32'(err_count),     32'(e_cnt));
        chk({tag, "_ir"},  32'(bus.in_ready),  32'(e_ir));
    endtask

    task automatic drive(input logic v, input logic [8:0] d, input logic [1:0] m,
                         input logic dr, input logic ordy, input logic cl);
        bus.in_valid  = v;
        bus.in_data   = d;
        mode          = m;
        drop_err      = dr;
        bus.out_ready = ordy;
        err_clr       = cl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] pl [6];

    initial begin
        //        vld data    md dr or cl | ov od    oe lk cnt ir
        vecs[0]  = '{1, 9'h1AB, 2, 0, 1, 0,  0, 6'h00, 0, 0, 8'd0, 1};
        vecs[1]  = '{1, 9'h1AB, 2, 0, 1, 0,  0, 6'h00, 0, 0, 8'd0, 1};
        vecs[2]  = '{1, 9'h1AB, 2, 0, 1, 0,  0, 6'h00, 0, 1, 8'd0, 1};
        vecs[3]  = '{1, 9'h1AB, 2, 0, 1, 0,  1, 6'h2A, 0, 1, 8'd0, 1};
        vecs[4]  = '{1, 9'h1AB, 2, 0, 1, 0,  1, 6'h2A, 0, 1, 8'd0, 1};
        vecs[5]  = '{0, 9'h000, 2, 0, 1, 0,  0, 6'h00, 0, 1, 8'd0, 1};
        vecs[6]  = '{1, 9'h1A9, 2, 0, 1, 0,  1, 6'h2A, 1, 1, 8'd1, 1};
        vecs[7]  = '{1, 9'h1AB, 2, 0, 1, 0,  1, 6'h2A, 0, 1, 8'd1, 1};
        vecs[8]  = '{0, 9'h000, 2, 0, 1, 0,  0, 6'h00, 0, 1, 8'd1, 1};
        vecs[9]  = '{1, 9'h1A9, 1, 0, 1, 0,  1, 6'h2A, 0, 1, 8'd1, 1};
        vecs[10] = '{1, 9'h0AB, 1, 0, 1, 0,  1, 6'h2A, 1, 1, 8'd2, 1};
        vecs[11] = '{1, 9'h0AB, 1, 0, 1, 0,  1, 6'h2A, 1, 0, 8'd3, 1};
        vecs[12] = '{0, 9'h000, 1, 0, 1, 0,  0, 6'h00, 0, 0, 8'd3, 1};
        vecs[13] = '{1, 9'h1AB, 2, 0, 1, 0,  0, 6'h00, 0, 0, 8'd3, 1};
        vecs[14] = '{1, 9'h1AB, 2, 0, 1, 0,  0, 6'h00, 0, 0, 8'd3, 1};
        vecs[15] = '{1, 9'h1AB, 2, 0, 1, 0,  0, 6'h00, 0, 1, 8'd3, 1};
        vecs[16] = '{1, 9'h1A9, 2, 1, 1, 0,  0, 6'h00, 0, 1, 8'd4, 1};
        vecs[17] = '{1, 9'h1AB, 2, 1, 1, 0,  1, 6'h2A, 0, 1, 8'd4, 1};
        vecs[18] = '{0, 9'h000, 2, 1, 1, 0,  0, 6'h00, 0, 1, 8'd4, 1};
        vecs[19] = '{1, 9'h1A9, 3, 0, 1, 0,  1, 6'h2A, 1, 1, 8'd5, 1};
        vecs[20] = '{0, 9'h000, 3, 0, 1, 0,  0, 6'h00, 0, 1, 8'd5, 1};
        vecs[21] = '{1, 9'h07E, 0, 0, 1, 0,  1, 6'h1F, 0, 1, 8'd5, 1};
        vecs[22] = '{0, 9'h000, 0, 0, 1, 0,  0, 6'h00, 0, 1, 8'd5, 1};

        pl[0] = 6'h01; pl[1] = 6'h12; pl[2] = 6'h23;
        pl[3] = 6'h34; pl[4] = 6'h05; pl[5] = 6'h3F;

        // reset state
        rst_n = 1'b0;
        drive(0, 9'h000, 2, 0, 1, 0);
        step();
        step();
        chk_all("rst", 0, 6'h00, 0, 0, 8'd0, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ir", 32'(bus.in_ready), 32'd1);

        // lock acquisition, error tagging, mode changes, loss of lock, drop_err
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].vld, vecs[i].data, vecs[i].md, vecs[i].drop, vecs[i].ordy, vecs[i].clr);
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_oe,
                    vecs[i].e_lk, vecs[i].e_cnt, vecs[i].e_ir);
        end

        // backpressure: six good words offered, only four fit
        for (int i = 0; i < 6; i++) begin
            drive(1, mkw(pl[i < 4 ? i : 4]), 2, 0, 0, 0);
            step();
            chk($sformatf("fill%0d_ir", i), 32'(bus.in_ready), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_od", i), 32'(bus.out_data), 32'(pl[0]));
        end
        drive(1, mkw(pl[4]), 2, 0, 1, 0);
        step();
        chk("bp_pop_od", 32'(bus.out_data), 32'(pl[1]));
        chk("bp_pop_ir", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_pp_od", 32'(bus.out_data), 32'(pl[2]));
        chk("bp_pp_ir", 32'(bus.in_ready), 32'd1);
        drive(1, mkw(pl[5]), 2, 0, 0, 0);
        step();
        chk("bp_push_od", 32'(bus.out_data), 32'(pl[2]));
        chk("bp_push_ir", 32'(bus.in_ready), 32'd0);
        drive(0, 9'h000, 2, 0, 1, 0);
        for (int i = 3; i < 6; i++) begin
            step();
            chk($sformatf("drain%0d_ov", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("drain%0d_od", i), 32'(bus.out_data), 32'(pl[i]));
        end
        step();
        chk("drain_empty_ov", 32'(bus.out_valid), 32'd0);
        chk("drain_empty_od", 32'(bus.out_data), 32'd0);
        chk("bp_lk", 32'(locked), 32'd1);
        chk("bp_cnt", 32'(err_count), 32'd5);

        // counter saturation: 5 already counted, 250 more reach all-ones
        drive(1, 9'h0AB, 2, 1, 1, 0);
        for (int i = 0; i < 250; i++) step();
        chk("sat_ff", 32'(err_count), 32'hFF);
        chk("sat_lk", 32'(locked), 32'd0);
        step();
        chk("sat_hold", 32'(err_count), 32'hFF);
        drive(1, 9'h0AB, 2, 1, 1, 1);
        step();
        chk("clr_wins", 32'(err_count), 32'd0);
        drive(0, 9'h000, 2, 0, 1, 0);
        step();
        chk("clr_after", 32'(err_count), 32'd0);

        // mid-stream reset with three entries held
        drive(1, 9'h0AB, 2, 0, 1, 0);
        step();
        drive(1, 9'h1AB, 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) step();
        chk("mr_lk", 32'(locked), 32'd1);
        drive(1, 9'h1AB, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        chk_all("mr_pre", 1, 6'h2A, 0, 1, 8'd1, 1);
        rst_n = 1'b0;
        step();
        chk_all("mr_rst", 0, 6'h00, 0, 0, 8'd0, 0);
        rst_n = 1'b1;
        drive(0, 9'h000, 2, 0, 1, 0);
        #1;
        chk("mr_rel_ir", 32'(bus.in_ready), 32'd1);
        step();
        chk_all("mr_post", 0, 6'h00, 0, 0, 8'd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
